// File: rtl/mips32_data_mem_responder_if.sv
// Request/response bus between the MIPS32 MEM stage (master) and the data-memory responder (slave).
interface mips32_data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mips32_data_mem_responder.sv
// Word-addressed data memory with programmable wait states and a valid/ready response channel.
// Define MEM_STORE_ACK_EN to make stores return a response (rdata=0, err from the range check).
module mips32_data_mem_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned AW          = 10,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                          clk1,
    input  logic                          rst,
    mips32_data_mem_responder_if.slave    bus,
    output logic                          busy
);
    localparam int unsigned CW = 4;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WAIT   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;
    localparam logic [CW-1:0] WS_LOAD = CW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    localparam logic [1:0] AFTER_ACCEPT = (WAIT_STATES > 0) ? WAIT : ACCESS;

    logic [1:0]    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          accept;
    logic          addr_err;
    logic [AW-1:0] idx;
    logic [31:0]   mem [DEPTH];

    assign accept   = bus.req_valid && bus.req_ready;
    assign addr_err = |addr_q[31:AW];
    assign idx      = addr_q[AW-1:0];

    // Next-state logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = AFTER_ACCEPT;
                    cnt_nxt   = WS_LOAD;
                end
            end
            WAIT: begin
                if (cnt == '0) state_nxt = ACCESS;
                else           cnt_nxt   = cnt - CW'(1);
            end
            ACCESS: begin
`ifdef MEM_STORE_ACK_EN
                state_nxt = RESP;
`else
                state_nxt = we_q ? IDLE : RESP;
`endif
            end
            RESP: begin
                if (bus.rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, registered outputs and request capture
    always_ff @(posedge clk1) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            busy          <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            bus.req_ready <= (state_nxt == IDLE);
            bus.rsp_valid <= (state_nxt == RESP);
            busy          <= (state_nxt != IDLE);
            if (accept) begin
                we_q    <= bus.req_we;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (state == ACCESS) begin
                bus.rsp_rdata <= (we_q || addr_err) ? 32'd0 : mem[idx];
                bus.rsp_err   <= addr_err;
            end
        end
    end

    // Reset on the ACCESS edge cancels the store
    always_ff @(posedge clk1) begin
        if (!rst && state == ACCESS && we_q && !addr_err) mem[idx] <= wdata_q;
    end
endmodule

// File: tb/tb_mips32_data_mem_responder.sv
module tb_mips32_data_mem_responder;
`ifdef MEM_STORE_ACK_EN
    localparam bit ACK = 1'b1;
`else
    localparam bit ACK = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rv[2], wev[2], rr[2];
    logic [31:0] av[2], dv[2];
    logic        busy0, busy1;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    logic [31:0] mdl [2][16];
    vec_t        vt [7];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mips32_data_mem_responder_if bus0();
    mips32_data_mem_responder_if bus1();

    assign bus0.req_valid = rv[0];
    assign bus0.req_we    = wev[0];
    assign bus0.req_addr  = av[0];
    assign bus0.req_wdata = dv[0];
    assign bus0.rsp_ready = rr[0];
    assign bus1.req_valid = rv[1];
    assign bus1.req_we    = wev[1];
    assign bus1.req_addr  = av[1];
    assign bus1.req_wdata = dv[1];
    assign bus1.rsp_ready = rr[1];

    mips32_data_mem_responder #(.DEPTH(1024), .AW(10), .WAIT_STATES(2)) dut0 (
        .clk1(clk), .rst(rst), .bus(bus0), .busy(busy0));
    mips32_data_mem_responder #(.DEPTH(1024), .AW(10), .WAIT_STATES(0)) dut1 (
        .clk1(clk), .rst(rst), .bus(bus1), .busy(busy1));

    function automatic logic rdy(input int s);
        return (s == 0) ? bus0.req_ready : bus1.req_ready;
    endfunction
    function automatic logic vld(input int s);
        return (s == 0) ? bus0.rsp_valid : bus1.rsp_valid;
    endfunction
    function automatic logic [31:0] rdat(input int s);
        return (s == 0) ? bus0.rsp_rdata : bus1.rsp_rdata;
    endfunction
    function automatic logic errv(input int s);
        return (s == 0) ? bus0.rsp_err : bus1.rsp_err;
    endfunction
    function automatic logic bsy(input int s);
        return (s == 0) ? busy0 : busy1;
    endfunction
    function automatic int ws(input int s);
        return (s == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // One request; returns when the response appears or the responder is ready again
    task automatic txn(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic ready_hi, output logic [31:0] rd, output logic e,
                       output int lat, output logic got);
        int n = 0;
        while (!rdy(s) && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin
            checks++; failures++;
            $display("FAIL req_ready_timeout actual=0 required=1");
        end
        rv[s] = 1'b1; wev[s] = w; av[s] = a; dv[s] = d; rr[s] = ready_hi;
        acc_cyc = cyc;
        @(negedge clk);
        rv[s] = 1'b0; wev[s] = 1'b0; av[s] = $urandom; dv[s] = $urandom;
        lat = 1;
        while (!vld(s) && !rdy(s) && lat < 100) begin @(negedge clk); lat++; end
        got = vld(s);
        rd  = rdat(s);
        e   = errv(s);
    endtask

    task automatic hold_release(input int s, input int k, input logic [31:0] exp_rd, input logic exp_e);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            chk("bp_hold", {30'd0, vld(s), rdy(s), rdat(s), 1'b0, errv(s)},
                {30'd0, 1'b1, 1'b0, exp_rd, 1'b0, exp_e});
        end
        rr[s] = 1'b1;
        @(negedge clk);
        chk("bp_release", {62'd0, vld(s), rdy(s)}, {62'd0, 1'b0, 1'b1});
    endtask

    task automatic rst_during(input int s, input int k, input logic [31:0] a, input logic [31:0] d);
        while (!rdy(s)) @(negedge clk);
        rv[s] = 1'b1; wev[s] = 1'b1; av[s] = a; dv[s] = d; rr[s] = 1'b1;
        @(negedge clk);
        rv[s] = 1'b0;
        for (int i = 1; i < k; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid", {61'd0, rdy(s), bsy(s), vld(s)}, {61'd0, 1'b1, 1'b0, 1'b0});
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, exp_rd, a, d;
        logic        e, got, w, exp_e, exp_got, bp;
        int          lat, s, prev;

        vt[0] = '{1'b1, 32'd5,          32'hDEADBEEF, 32'd0,        1'b0};
        vt[1] = '{1'b0, 32'd5,          32'd0,        32'hDEADBEEF, 1'b0};
        vt[2] = '{1'b0, 32'd1024,       32'd0,        32'd0,        1'b1};
        vt[3] = '{1'b1, 32'h0001_0005,  32'd1,        32'd0,        1'b1};
        vt[4] = '{1'b0, 32'd5,          32'd0,        32'hDEADBEEF, 1'b0};
        vt[5] = '{1'b1, 32'd9,          32'h99,       32'd0,        1'b0};
        vt[6] = '{1'b0, 32'd9,          32'd0,        32'h99,       1'b0};

        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0; wev[i] = 1'b0; rr[i] = 1'b1; av[i] = '0; dv[i] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 2; j++)
                chk("reset_idle", {29'd0, rdy(j), vld(j), bsy(j), rdat(j)},
                    {29'd0, 1'b1, 1'b0, 1'b0, 32'd0});
            @(negedge clk);
        end

        // Directed vectors on the 2-wait-state responder
        for (int i = 0; i < 7; i++) begin
            txn(0, vt[i].we, vt[i].addr, vt[i].wdata, 1'b1, rd, e, lat, got);
            exp_got = !vt[i].we || ACK;
            chk("vec_got", 64'(got), 64'(exp_got));
            chk("vec_lat", 64'(lat), 64'd4);
            if (exp_got) chk("vec_rsp", {31'd0, e, rd}, {31'd0, vt[i].exp_err, vt[i].exp_rdata});
        end

        // Backpressure on a load
        txn(0, 1'b0, 32'd5, 32'd0, 1'b0, rd, e, lat, got);
        chk("bp_first", {30'd0, got, e, rd}, {30'd0, 1'b1, 1'b0, 32'hDEADBEEF});
        hold_release(0, 6, 32'hDEADBEEF, 1'b0);

        // Reset while the store waits, and on the ACCESS edge itself
        rst_during(0, 1, 32'd9, 32'd7);
        txn(0, 1'b0, 32'd9, 32'd0, 1'b1, rd, e, lat, got);
        chk("rst_wait_keep", {31'd0, got, rd}, {31'd0, 1'b1, 32'h99});
        rst_during(0, 3, 32'd9, 32'd8);
        txn(0, 1'b0, 32'd9, 32'd0, 1'b1, rd, e, lat, got);
        chk("rst_access_keep", {31'd0, got, rd}, {31'd0, 1'b1, 32'h99});

        // Zero wait states: stores then back-to-back loads
        for (int i = 0; i < 8; i++) begin
            txn(1, 1'b1, 32'(i), 32'(100 + i), 1'b1, rd, e, lat, got);
            chk("ws0_store_lat", 64'(lat), 64'd2);
        end
        prev = -1;
        for (int i = 0; i < 8; i++) begin
            txn(1, 1'b0, 32'(i), 32'd0, 1'b1, rd, e, lat, got);
            chk("ws0_load", {30'd0, got, e, rd}, {30'd0, 1'b1, 1'b0, 32'(100 + i)});
            chk("ws0_lat", 64'(lat), 64'd2);
            if (prev >= 0) chk("ws0_period", 64'(acc_cyc - prev), 64'd3);
            prev = acc_cyc;
        end

        // Randomized traffic against a word-array model
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 2; j++) begin
                d = $urandom;
                txn(j, 1'b1, 32'(i), d, 1'b1, rd, e, lat, got);
                mdl[j][i] = d;
            end
        for (int n = 0; n < 60; n++) begin
            s  = int'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            bp = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) a = a | (32'($urandom_range(1, 65535)) << 10);
            d  = $urandom;
            exp_e   = (a >= 32'd1024);
            exp_got = !w || ACK;
            exp_rd  = (w || exp_e) ? 32'd0 : mdl[s][a[3:0]];
            if (w && !exp_e) mdl[s][a[3:0]] = d;
            txn(s, w, a, d, !bp, rd, e, lat, got);
            chk("rnd_got", 64'(got), 64'(exp_got));
            chk("rnd_lat", 64'(lat), 64'(ws(s) + 2));
            if (exp_got) chk("rnd_rsp", {31'd0, e, rd}, {31'd0, exp_e, exp_rd});
            if (got && bp) hold_release(s, int'($urandom_range(0, 3)), exp_rd, exp_e);
            rr[s] = 1'b1;
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
